// File: rtl/alu_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_checker_if
// Description : Observation bus of the 8-bit ALU: the operand/opcode sample
//               driven into the ALU and the ALU result seen by the checker.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_checker_if;
  logic       sample_valid;
  logic [2:0] opcode;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] out;

  // Stimulus side drives the whole bus (operands and the ALU result)
  modport master (output sample_valid, opcode, a, b, out);
  // Checker side only observes
  modport slave  (input  sample_valid, opcode, a, b, out);
endinterface
`default_nettype wire

// File: rtl/alu_checker.sv
`default_nettype none
// ============================================================================
// Module      : alu_checker
// Description : Cycle-based response checker for the 8-bit ALU. Recomputes
//               the expected result with a golden model, delays it by LAT
//               cycles, compares against the ALU output and keeps saturating
//               pass/fail statistics plus a first-failure capture.
//               Optional per-opcode fail histogram: define ALU_CHECKER_HIST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_checker #(
  parameter int LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        halt_on_fail,
  alu_checker_if.slave bus,
  output logic [15:0] pass_cnt,
  output logic [15:0] fail_cnt,
  output logic        mismatch,
  output logic        busy,
  output logic        halted,
  output logic [2:0]  ff_opcode,
  output logic [7:0]  ff_a,
  output logic [7:0]  ff_b,
  output logic [7:0]  ff_out,
  output logic [7:0]  ff_exp,
  output logic        ff_valid
`ifdef ALU_CHECKER_HIST_EN
  ,
  output logic [63:0] op_fail_hist
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0] state;

  // Sample as seen at the compare point (current cycle or LAT cycles late)
  logic       cmp_valid;
  logic [2:0] cmp_op;
  logic [7:0] cmp_a;
  logic [7:0] cmp_b;
  logic [7:0] cmp_exp;
  logic [7:0] cur_exp;
  logic       cmp_evt;
  logic       cmp_fail;

  function automatic logic [7:0] golden(input logic [2:0] op,
                                        input logic [7:0] x,
                                        input logic [7:0] y);
    logic [7:0] r;
    case (op)
      3'd0:    r = x + y;
      3'd1:    r = x - y;
      3'd2:    r = x & y;
      3'd3:    r = x | y;
      3'd4:    r = x ^ y;
      3'd5:    r = ~x;
      3'd6:    r = {x[6:0], 1'b0};
      default: r = {1'b0, x[7:1]};
    endcase
    return r;
  endfunction

  assign cur_exp = golden(bus.opcode, bus.a, bus.b);

  generate
    if (LAT == 0) begin : g_comb
      assign cmp_valid = bus.sample_valid;
      assign cmp_op    = bus.opcode;
      assign cmp_a     = bus.a;
      assign cmp_b     = bus.b;
      assign cmp_exp   = cur_exp;
    end else begin : g_pipe
      logic [LAT-1:0] v_q;
      logic [2:0]     op_q  [LAT];
      logic [7:0]     a_q   [LAT];
      logic [7:0]     b_q   [LAT];
      logic [7:0]     exp_q [LAT];

      // Data side of the delay chain; only the valids need clearing
      always_ff @(posedge clk) begin
        op_q[0]  <= bus.opcode;
        a_q[0]   <= bus.a;
        b_q[0]   <= bus.b;
        exp_q[0] <= cur_exp;
        for (int i = 1; i < LAT; i++) begin
          op_q[i]  <= op_q[i-1];
          a_q[i]   <= a_q[i-1];
          b_q[i]   <= b_q[i-1];
          exp_q[i] <= exp_q[i-1];
        end
      end

      // Valid chain; start flushes it so stale in-flight samples are never scored
      always_ff @(posedge clk) begin
        if (rst || start) begin
          v_q <= '0;
        end else begin
          v_q[0] <= bus.sample_valid;
          for (int i = 1; i < LAT; i++) begin
            v_q[i] <= v_q[i-1];
          end
        end
      end

      assign cmp_valid = v_q[LAT-1];
      assign cmp_op    = op_q[LAT-1];
      assign cmp_a     = a_q[LAT-1];
      assign cmp_b     = b_q[LAT-1];
      assign cmp_exp   = exp_q[LAT-1];
    end
  endgenerate

  assign cmp_evt  = cmp_valid && (state == S_RUN);
  assign cmp_fail = cmp_evt && (bus.out != cmp_exp);
  assign busy     = (state == S_RUN);
  assign halted   = (state == S_HALT);

  // Control state, statistics and first-failure capture; start overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pass_cnt  <= 16'd0;
      fail_cnt  <= 16'd0;
      mismatch  <= 1'b0;
      ff_valid  <= 1'b0;
      ff_opcode <= 3'd0;
      ff_a      <= 8'd0;
      ff_b      <= 8'd0;
      ff_out    <= 8'd0;
      ff_exp    <= 8'd0;
`ifdef ALU_CHECKER_HIST_EN
      op_fail_hist <= 64'd0;
`endif
    end else begin
      mismatch <= 1'b0;
      if (start) begin
        state    <= S_RUN;
        pass_cnt <= 16'd0;
        fail_cnt <= 16'd0;
        ff_valid <= 1'b0;
`ifdef ALU_CHECKER_HIST_EN
        op_fail_hist <= 64'd0;
`endif
      end else begin
        if (cmp_fail) begin
          mismatch <= 1'b1;
          if (fail_cnt != 16'hFFFF) begin
            fail_cnt <= fail_cnt + 16'd1;
          end
          if (!ff_valid) begin
            ff_valid  <= 1'b1;
            ff_opcode <= cmp_op;
            ff_a      <= cmp_a;
            ff_b      <= cmp_b;
            ff_out    <= bus.out;
            ff_exp    <= cmp_exp;
          end
`ifdef ALU_CHECKER_HIST_EN
          if (op_fail_hist[{cmp_op, 3'b000} +: 8] != 8'hFF) begin
            op_fail_hist[{cmp_op, 3'b000} +: 8] <= op_fail_hist[{cmp_op, 3'b000} +: 8] + 8'd1;
          end
`endif
        end else if (cmp_evt) begin
          if (pass_cnt != 16'hFFFF) begin
            pass_cnt <= pass_cnt + 16'd1;
          end
        end

        if (stop) begin
          state <= S_IDLE;
        end else if (cmp_fail && halt_on_fail) begin
          state <= S_HALT;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_checker
// Description : Scoreboard bench for alu_checker. Two instances (LAT=0 and
//               LAT=2) observe the same operand stream; a reference model
//               predicts every scored compare and the final statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_checker;

  localparam int LAT1    = 2;
  localparam int ST_IDLE = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_HALT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic hof = 1'b0;

  always #5 clk = ~clk;

  alu_checker_if bus0 ();
  alu_checker_if bus1 ();

  logic [15:0] pass_cnt [2];
  logic [15:0] fail_cnt [2];
  logic        mismatch [2];
  logic        busy     [2];
  logic        halted   [2];
  logic        ff_valid [2];
  logic [2:0]  ff_opcode[2];
  logic [7:0]  ff_a     [2];
  logic [7:0]  ff_b     [2];
  logic [7:0]  ff_out   [2];
  logic [7:0]  ff_exp   [2];
`ifdef ALU_CHECKER_HIST_EN
  logic [63:0] hist     [2];
`endif

  alu_checker #(.LAT(0)) u_comb (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .halt_on_fail(hof),
    .bus(bus0),
    .pass_cnt(pass_cnt[0]), .fail_cnt(fail_cnt[0]), .mismatch(mismatch[0]),
    .busy(busy[0]), .halted(halted[0]), .ff_opcode(ff_opcode[0]),
    .ff_a(ff_a[0]), .ff_b(ff_b[0]), .ff_out(ff_out[0]), .ff_exp(ff_exp[0]),
    .ff_valid(ff_valid[0])
`ifdef ALU_CHECKER_HIST_EN
    , .op_fail_hist(hist[0])
`endif
  );

  alu_checker #(.LAT(LAT1)) u_pipe (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .halt_on_fail(hof),
    .bus(bus1),
    .pass_cnt(pass_cnt[1]), .fail_cnt(fail_cnt[1]), .mismatch(mismatch[1]),
    .busy(busy[1]), .halted(halted[1]), .ff_opcode(ff_opcode[1]),
    .ff_a(ff_a[1]), .ff_b(ff_b[1]), .ff_out(ff_out[1]), .ff_exp(ff_exp[1]),
    .ff_valid(ff_valid[1])
`ifdef ALU_CHECKER_HIST_EN
    , .op_fail_hist(hist[1])
`endif
  );

  typedef struct packed {
    logic       f;
    logic [7:0] e;
    logic [7:0] o;
  } sb_t;

  sb_t q0[$];
  sb_t q1[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, one slot per instance
  int          m_state [2];
  logic [15:0] m_pass  [2];
  logic [15:0] m_fail  [2];
  logic        m_ffv   [2];
  logic [2:0]  m_ffop  [2];
  logic [7:0]  m_ffa   [2];
  logic [7:0]  m_ffb   [2];
  logic [7:0]  m_ffo   [2];
  logic [7:0]  m_ffe   [2];
  int          m_hist  [2][8];
  logic        md_v  [LAT1];
  logic [2:0]  md_op [LAT1];
  logic [7:0]  md_a  [LAT1];
  logic [7:0]  md_b  [LAT1];
  logic [7:0]  line_out [LAT1];
  logic [15:0] prev_pass [2];

  function automatic logic [7:0] gold(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    int ia, ib, r;
    ia = x;
    ib = y;
    case (op)
      3'd0: r = ia + ib;
      3'd1: r = ia - ib + 256;
      3'd2: r = int'(x & y);
      3'd3: r = int'(x | y);
      3'd4: r = int'(x ^ y);
      3'd5: r = 255 - ia;
      3'd6: r = ia * 2;
      default: r = ia / 2;
    endcase
    return 8'(r % 256);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_state[d] = ST_IDLE;
      m_pass[d] = 0; m_fail[d] = 0; m_ffv[d] = 0;
      m_ffop[d] = 0; m_ffa[d] = 0; m_ffb[d] = 0; m_ffo[d] = 0; m_ffe[d] = 0;
      for (int k = 0; k < 8; k++) m_hist[d][k] = 0;
    end
    for (int i = 0; i < LAT1; i++) md_v[i] = 0;
  endtask

  // Predict what instance d does at the coming clock edge
  task automatic model_edge(input int d, input logic sv, input logic [2:0] op,
                            input logic [7:0] a, input logic [7:0] b, input logic [7:0] o);
    logic ev, f;
    logic [2:0] eo;
    logic [7:0] ea, eb, e;
    sb_t s;
    if (d == 0) begin
      ev = sv; eo = op; ea = a; eb = b;
    end else begin
      ev = md_v[LAT1-1]; eo = md_op[LAT1-1]; ea = md_a[LAT1-1]; eb = md_b[LAT1-1];
      for (int i = LAT1 - 1; i > 0; i--) begin
        md_v[i] = md_v[i-1]; md_op[i] = md_op[i-1]; md_a[i] = md_a[i-1]; md_b[i] = md_b[i-1];
      end
      md_v[0] = sv; md_op[0] = op; md_a[0] = a; md_b[0] = b;
    end
    f = 1'b0;
    if (start) begin
      m_state[d] = ST_RUN;
      m_pass[d] = 0; m_fail[d] = 0; m_ffv[d] = 0;
      for (int k = 0; k < 8; k++) m_hist[d][k] = 0;
      if (d == 1) for (int i = 0; i < LAT1; i++) md_v[i] = 0;
    end else begin
      if (m_state[d] == ST_RUN && ev) begin
        e = gold(eo, ea, eb);
        f = (o != e);
        s.f = f; s.e = e; s.o = o;
        if (f) begin
          if (d == 0) q0.push_back(s); else q1.push_back(s);
          if (m_fail[d] < 16'hFFFF) m_fail[d]++;
          if (!m_ffv[d]) begin
            m_ffv[d] = 1; m_ffop[d] = eo; m_ffa[d] = ea; m_ffb[d] = eb; m_ffo[d] = o; m_ffe[d] = e;
          end
          if (m_hist[d][eo] < 255) m_hist[d][eo]++;
        end else if (m_pass[d] < 16'hFFFF) begin
          if (d == 0) q0.push_back(s); else q1.push_back(s);
          m_pass[d]++;
        end
      end
      if (stop) m_state[d] = ST_IDLE;
      else if (f && hof) m_state[d] = ST_HALT;
    end
  endtask

  // Drive one cycle of stimulus; out for the pipelined instance lags by LAT1
  task automatic cycle(input logic sv, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] flip, input logic st, input logic sp);
    logic [7:0] o0;
    o0 = gold(op, a, b) ^ flip;
    bus0.sample_valid = sv; bus0.opcode = op; bus0.a = a; bus0.b = b; bus0.out = o0;
    bus1.sample_valid = sv; bus1.opcode = op; bus1.a = a; bus1.b = b; bus1.out = line_out[LAT1-1];
    start = st;
    stop = sp;
    model_edge(0, sv, op, a, b, o0);
    model_edge(1, sv, op, a, b, line_out[LAT1-1]);
    for (int i = LAT1 - 1; i > 0; i--) line_out[i] = line_out[i-1];
    line_out[0] = o0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    bus0.sample_valid = 1'b0;
    bus1.sample_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Full comparison of both instances against the model
  task automatic snap(input string tag);
    int sz;
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_pass_d%0d", tag, d), pass_cnt[d], m_pass[d]);
      chk($sformatf("%s_fail_d%0d", tag, d), fail_cnt[d], m_fail[d]);
      chk($sformatf("%s_busy_d%0d", tag, d), busy[d], m_state[d] == ST_RUN);
      chk($sformatf("%s_halted_d%0d", tag, d), halted[d], m_state[d] == ST_HALT);
      chk($sformatf("%s_mismatch_d%0d", tag, d), mismatch[d], 0);
      chk($sformatf("%s_ffvalid_d%0d", tag, d), ff_valid[d], m_ffv[d]);
      chk($sformatf("%s_ffcap_d%0d", tag, d), {ff_opcode[d], ff_a[d], ff_b[d], ff_out[d], ff_exp[d]},
          {m_ffop[d], m_ffa[d], m_ffb[d], m_ffo[d], m_ffe[d]});
      sz = (d == 0) ? q0.size() : q1.size();
      chk($sformatf("%s_sb_leftover_d%0d", tag, d), sz, 0);
`ifdef ALU_CHECKER_HIST_EN
      for (int k = 0; k < 8; k++)
        chk($sformatf("%s_hist%0d_d%0d", tag, k, d), hist[d][k*8 +: 8], m_hist[d][k]);
`endif
    end
  endtask

  // Monitor: every mismatch pulse or pass increment consumes one prediction
  task automatic mon(input int d, input logic mis, input logic [15:0] pc);
    sb_t s;
    int sz;
    if (mis === 1'b1 || pc > prev_pass[d]) begin
      sz = (d == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
        chk($sformatf("sb_unexpected_event_d%0d", d), sz, 1);
      end else begin
        s = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("sb_outcome_d%0d_exp%0h_out%0h", d, s.e, s.o), mis, s.f);
        if (mis !== 1'b1) chk($sformatf("sb_pass_step_d%0d", d), pc, prev_pass[d] + 16'd1);
      end
    end
    prev_pass[d] = pc;
  endtask

  always @(negedge clk) begin
    mon(0, mismatch[0], pass_cnt[0]);
    mon(1, mismatch[1], pass_cnt[1]);
  end

  initial begin
    prev_pass[0] = 0;
    prev_pass[1] = 0;
    bus0.sample_valid = 0; bus0.opcode = 0; bus0.a = 0; bus0.b = 0; bus0.out = 0;
    bus1.sample_valid = 0; bus1.opcode = 0; bus1.a = 0; bus1.b = 0; bus1.out = 0;
    for (int i = 0; i < LAT1; i++) begin
      line_out[i] = 0; md_op[i] = 0; md_a[i] = 0; md_b[i] = 0;
    end
    do_reset();
    snap("reset");

    // Directed pass, first failure, second failure
    cycle(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 3'd0, 8'h7F, 8'h01, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 3'd1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0);
    cycle(1'b1, 3'd2, 8'hF0, 8'h0F, 8'h01, 1'b0, 1'b0);
    idle(3);
    snap("directed");
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dir_pass_d%0d", d), pass_cnt[d], 16'd1);
      chk($sformatf("dir_fail_d%0d", d), fail_cnt[d], 16'd2);
      chk($sformatf("dir_ffexp_d%0d", d), ff_exp[d], 8'hFF);
      chk($sformatf("dir_ffout_d%0d", d), ff_out[d], 8'h00);
      chk($sformatf("dir_ffop_d%0d", d), ff_opcode[d], 3'd1);
      chk($sformatf("dir_ffvalid_d%0d", d), ff_valid[d], 1'b1);
    end

    // Randomized traffic with occasional start/stop (including both at once)
    cycle(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [7:0] flip;
      r = $urandom_range(0, 99);
      flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      cycle($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), flip,
            r < 3, r >= 2 && r < 6);
    end
    idle(3);
    snap("random");

    // Halt on first failure
    hof = 1'b1;
    cycle(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 3'd6, 8'h81, 8'h00, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 3'd4, 8'h3C, 8'h55, 8'h10, 1'b0, 1'b0);
    cycle(1'b1, 3'd3, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 3'd0, 8'h12, 8'h34, 8'h04, 1'b0, 1'b0);
    idle(3);
    snap("halt");
    chk("halt_pass", pass_cnt[1], 16'd1);
    chk("halt_fail", fail_cnt[1], 16'd1);
    chk("halt_halted", halted[1], 1'b1);
    chk("halt_busy", busy[1], 1'b0);
    cycle(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    hof = 1'b0;
    snap("halt_stop");

    // start and stop together from IDLE
    cycle(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    snap("start_stop");
    chk("ss_busy", busy[0], 1'b1);
    chk("ss_counts", {pass_cnt[0], fail_cnt[0]}, 32'd0);

    // Reset with samples in flight
    cycle(1'b1, 3'd0, 8'h01, 8'h02, 8'h40, 1'b0, 1'b0);
    cycle(1'b1, 3'd1, 8'h05, 8'h02, 8'h40, 1'b0, 1'b0);
    cycle(1'b1, 3'd7, 8'h80, 8'h00, 8'h40, 1'b0, 1'b0);
    do_reset();
    idle(4);
    snap("rst_run");
    chk("rst_fail_pipe", fail_cnt[1], 16'd0);
    chk("rst_busy_pipe", busy[1], 1'b0);

    // Pass counter saturation
    cycle(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 65534; i++)
      cycle(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'h00, 1'b0, 1'b0);
    idle(2);
    snap("sat_pre");
    chk("sat_pre_val", pass_cnt[1], 16'hFFFE);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 3'd3, 8'($urandom), 8'($urandom), 8'h00, 1'b0, 1'b0);
    idle(2);
    snap("sat_post");
    chk("sat_post_comb", pass_cnt[0], 16'hFFFF);
    chk("sat_post_pipe", pass_cnt[1], 16'hFFFF);

`ifdef ALU_CHECKER_HIST_EN
    cycle(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 3'd2, 8'hAA, 8'h0F, 8'h01, 1'b0, 1'b0);
    cycle(1'b1, 3'd2, 8'h33, 8'hF0, 8'h80, 1'b0, 1'b0);
    cycle(1'b1, 3'd5, 8'h5A, 8'h00, 8'h02, 1'b0, 1'b0);
    idle(3);
    snap("hist");
    chk("hist_vec", hist[1], 64'h0000_0100_0002_0000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
